// File: rtl/cs_occupancy_tracker_pkg.sv
// Shared definitions for the channel occupancy tracker: FSM states, event type codes,
// default hysteresis counts and a saturating counter helper.
package cs_occupancy_tracker_pkg;

  typedef enum logic [1:0] {
    CS_VACANT   = 2'd0,
    CS_PEND_OCC = 2'd1,
    CS_OCCUPIED = 2'd2,
    CS_PEND_VAC = 2'd3
  } cs_state_e;

  localparam logic CS_EVT_VAC = 1'b0;
  localparam logic CS_EVT_OCC = 1'b1;

  localparam int CS_DEFAULT_ON_COUNT  = 4;
  localparam int CS_DEFAULT_OFF_COUNT = 8;

  // Statistics stick at all-ones instead of wrapping back to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/cs_event_fifo.sv
// First-word fall-through event FIFO with flush and a drop-on-full indication.
// A push while full only succeeds if the head is popped in the same cycle.
module cs_event_fifo #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/cs_occupancy_tracker.sv
// Debounces energy-detector decisions into a channel-occupied flag, logs timestamped
// occupancy transitions into an event FIFO and keeps saturating window statistics.
module cs_occupancy_tracker
  import cs_occupancy_tracker_pkg::*;
#(
  parameter int ON_COUNT   = CS_DEFAULT_ON_COUNT,
  parameter int OFF_COUNT  = CS_DEFAULT_OFF_COUNT,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        present_next,
  input  logic [31:0] present_nextcount,
  input  logic        clear,
  input  logic        irq_en,
  input  logic        evt_rd,
  output logic [31:0] evt_data,
  output logic        evt_valid,
  output logic        evt_overflow,
  output logic        occupied,
  output logic [31:0] occ_windows,
  output logic [31:0] total_windows,
  output logic        irq
);

  localparam logic [7:0] ON_LIM  = 8'(ON_COUNT);
  localparam logic [7:0] OFF_LIM = 8'(OFF_COUNT);

  if (FIFO_DEPTH != (1 << FIFO_AW)) begin : g_depth_check
    $error("FIFO_DEPTH must equal 2**FIFO_AW");
  end

  cs_state_e   state;
  logic [7:0]  streak;
  logic        primed;
  logic [31:0] last_count;
  logic [31:0] ts;
  logic        dec;
  logic        enter_occ;
  logic        enter_vac;
  logic        push_evt;
  logic [31:0] evt_word;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_overflow;

  assign dec = run && primed && (present_nextcount != last_count);

  // Transition pulses are needed combinationally so the push lands in the dec cycle.
  always_comb begin
    enter_occ = 1'b0;
    enter_vac = 1'b0;
    if (dec) begin
      unique case (state)
        CS_VACANT:   enter_occ = present_next && (ON_LIM == 8'd1);
        CS_PEND_OCC: enter_occ = present_next && ((streak + 8'd1) == ON_LIM);
        CS_OCCUPIED: enter_vac = !present_next && (OFF_LIM == 8'd1);
        CS_PEND_VAC: enter_vac = !present_next && ((streak + 8'd1) == OFF_LIM);
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CS_VACANT;
      streak   <= '0;
      occupied <= 1'b0;
    end else if (dec) begin
      unique case (state)
        CS_VACANT: begin
          if (present_next) begin
            if (enter_occ) begin
              state    <= CS_OCCUPIED;
              streak   <= '0;
              occupied <= 1'b1;
            end else begin
              state  <= CS_PEND_OCC;
              streak <= 8'd1;
            end
          end
        end
        CS_PEND_OCC: begin
          if (!present_next) begin
            state  <= CS_VACANT;
            streak <= '0;
          end else if (enter_occ) begin
            state    <= CS_OCCUPIED;
            streak   <= '0;
            occupied <= 1'b1;
          end else begin
            streak <= streak + 8'd1;
          end
        end
        CS_OCCUPIED: begin
          if (!present_next) begin
            if (enter_vac) begin
              state    <= CS_VACANT;
              streak   <= '0;
              occupied <= 1'b0;
            end else begin
              state  <= CS_PEND_VAC;
              streak <= 8'd1;
            end
          end
        end
        CS_PEND_VAC: begin
          if (present_next) begin
            state  <= CS_OCCUPIED;
            streak <= '0;
          end else if (enter_vac) begin
            state    <= CS_VACANT;
            streak   <= '0;
            occupied <= 1'b0;
          end else begin
            streak <= streak + 8'd1;
          end
        end
      endcase
    end
  end

  // Clear wins over a same-cycle decision: its statistics update is discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      primed        <= 1'b0;
      last_count    <= '0;
      ts            <= '0;
      total_windows <= '0;
      occ_windows   <= '0;
      evt_overflow  <= 1'b0;
    end else begin
      primed     <= 1'b1;
      last_count <= present_nextcount;
      if (clear) begin
        ts            <= '0;
        total_windows <= '0;
        occ_windows   <= '0;
        evt_overflow  <= 1'b0;
      end else begin
        if (run) ts <= ts + 32'd1;
        if (dec) begin
          total_windows <= sat_inc(total_windows);
          if (occupied) occ_windows <= sat_inc(occ_windows);
        end
        if (fifo_overflow) evt_overflow <= 1'b1;
      end
    end
  end

  assign push_evt = (enter_occ || enter_vac) && !clear;
  assign evt_word = {enter_occ ? CS_EVT_OCC : CS_EVT_VAC, ts[30:0]};

  cs_event_fifo #(
    .WIDTH(32),
    .AW   (FIFO_AW)
  ) u_event_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (clear),
    .push    (push_evt),
    .data_in (evt_word),
    .pop     (evt_rd),
    .data_out(evt_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .overflow(fifo_overflow)
  );

  assign evt_valid = !fifo_empty;
  assign irq       = irq_en && evt_valid;

endmodule

// File: tb/tb_cs_occupancy_tracker.sv
// Directed self-checking bench for cs_occupancy_tracker: hysteresis, event logging,
// FIFO full/overflow, clear priority, run gating, timestamp wrap and saturation.
module tb_cs_occupancy_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        present_next;
  logic [31:0] present_nextcount;
  logic        clear;
  logic        irq_en;
  logic        evt_rd;
  logic [31:0] evt_data;
  logic        evt_valid;
  logic        evt_overflow;
  logic        occupied;
  logic [31:0] occ_windows;
  logic [31:0] total_windows;
  logic        irq;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mts;
  logic [31:0] ts_at;
  logic        exp_ovf;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  cs_occupancy_tracker #(
    .ON_COUNT  (4),
    .OFF_COUNT (8),
    .FIFO_DEPTH(16),
    .FIFO_AW   (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .present_next     (present_next),
    .present_nextcount(present_nextcount),
    .clear            (clear),
    .irq_en           (irq_en),
    .evt_rd           (evt_rd),
    .evt_data         (evt_data),
    .evt_valid        (evt_valid),
    .evt_overflow     (evt_overflow),
    .occupied         (occupied),
    .occ_windows      (occ_windows),
    .total_windows    (total_windows),
    .irq              (irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; the reference timestamp follows run/clear/reset.
  task automatic applyStimulus(input logic r, input logic p, input logic bump,
                               input logic c, input logic rd);
    run          = r;
    present_next = p;
    clear        = c;
    evt_rd       = rd;
    if (bump) present_nextcount = present_nextcount + 32'd1;
    ts_at = mts;
    @(posedge clk);
    if (!rst || c) mts = 32'd0;
    else if (r) mts = mts + 32'd1;
    if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
    if (c) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end
    @(negedge clk);
    clear  = 1'b0;
    evt_rd = 1'b0;
  endtask

  task automatic decide(input logic p);
    applyStimulus(1'b1, p, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expectEvent(input logic typ);
    if (exp_q.size() < 16) exp_q.push_back({typ, ts_at[30:0]});
    else exp_ovf = 1'b1;
  endtask

  task automatic checkHead(input string tag);
    checkOutput({tag, "_valid"}, 32'(evt_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) checkOutput({tag, "_data"}, evt_data, exp_q[0]);
    checkOutput({tag, "_ovf"}, 32'(evt_overflow), 32'(exp_ovf));
  endtask

  initial begin
    rst = 1'b0; run = 1'b0; present_next = 1'b0; clear = 1'b0;
    irq_en = 1'b1; evt_rd = 1'b0; present_nextcount = 32'd5;
    mts = 32'd0; ts_at = 32'd0; exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_occupied", 32'(occupied), 32'd0);
    checkOutput("rst_valid", 32'(evt_valid), 32'd0);
    checkOutput("rst_data", evt_data, 32'd0);
    checkOutput("rst_total", total_windows, 32'd0);
    checkOutput("rst_occw", occ_windows, 32'd0);
    checkOutput("rst_ovf", 32'(evt_overflow), 32'd0);
    checkOutput("rst_irq", 32'(irq), 32'd0);
    rst = 1'b1;

    // Count held constant after reset: no decisions.
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("prime_total", total_windows, 32'd0);
    checkOutput("prime_occupied", 32'(occupied), 32'd0);
    checkOutput("prime_valid", 32'(evt_valid), 32'd0);

    for (int i = 0; i < 4; i++) begin
      decide(1'b1);
      if (i < 3) checkOutput("onset_wait", 32'(occupied), 32'd0);
    end
    expectEvent(1'b1);
    checkOutput("onset_occupied", 32'(occupied), 32'd1);
    checkHead("onset");
    checkOutput("onset_irq", 32'(irq), 32'd1);
    checkOutput("onset_total", total_windows, 32'd4);
    checkOutput("onset_occw", occ_windows, 32'd0);
    irq_en = 1'b0;
    #1 checkOutput("irq_masked", 32'(irq), 32'd0);
    irq_en = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("onset_popped", 32'(evt_valid), 32'd0);

    for (int i = 0; i < 8; i++) begin
      decide(1'b0);
      if (i < 7) checkOutput("offset_wait", 32'(occupied), 32'd1);
    end
    expectEvent(1'b0);
    checkOutput("offset_occupied", 32'(occupied), 32'd0);
    checkHead("offset");
    checkOutput("offset_occw", occ_windows, 32'd8);
    checkOutput("offset_total", total_windows, 32'd12);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (3) decide(1'b1);
    decide(1'b0);
    checkOutput("short_occupied", 32'(occupied), 32'd0);
    checkOutput("short_valid", 32'(evt_valid), 32'd0);
    checkOutput("short_total", total_windows, 32'd16);

    for (int i = 0; i < 20; i++) decide(i % 2 == 0);
    checkOutput("alt_valid", 32'(evt_valid), 32'd0);
    checkOutput("alt_occupied", 32'(occupied), 32'd0);
    checkOutput("alt_total", total_windows, 32'd36);
    checkOutput("alt_occw", occ_windows, 32'd8);

    // Sixteen transitions fill the FIFO exactly.
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        repeat (4) decide(1'b1);
        expectEvent(1'b1);
      end else begin
        repeat (8) decide(1'b0);
        expectEvent(1'b0);
      end
    end
    checkHead("full");
    checkOutput("full_occupied", 32'(occupied), 32'd0);

    repeat (3) decide(1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    expectEvent(1'b1);
    checkHead("poppush");
    checkOutput("poppush_ovf", 32'(evt_overflow), 32'd0);

    repeat (8) decide(1'b0);
    expectEvent(1'b0);
    checkOutput("drop_ovf", 32'(evt_overflow), 32'd1);
    checkHead("drop");
    repeat (4) decide(1'b1);
    expectEvent(1'b1);
    repeat (2) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checkHead("drain");
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("clear_valid", 32'(evt_valid), 32'd0);
    checkOutput("clear_ovf", 32'(evt_overflow), 32'd0);
    checkOutput("clear_total", total_windows, 32'd0);
    checkOutput("clear_occw", occ_windows, 32'd0);
    checkOutput("clear_occupied", 32'(occupied), 32'd1);

    // Clear on the deciding cycle: FSM still leaves OCCUPIED, nothing logged.
    repeat (7) decide(1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("cleardec_occupied", 32'(occupied), 32'd0);
    checkOutput("cleardec_valid", 32'(evt_valid), 32'd0);
    checkOutput("cleardec_total", total_windows, 32'd0);
    checkOutput("cleardec_occw", occ_windows, 32'd0);

    repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("norun_total", total_windows, 32'd0);
    checkOutput("norun_occupied", 32'(occupied), 32'd0);
    repeat (4) decide(1'b1);
    expectEvent(1'b1);
    checkHead("rerun");
    checkOutput("rerun_data", evt_data, 32'h8000_0003);
    checkOutput("rerun_total", total_windows, 32'd4);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    repeat (7) decide(1'b0);
    force dut.ts = 32'h7FFF_FFFE;
    release dut.ts;
    mts = 32'h7FFF_FFFE;
    decide(1'b0);
    expectEvent(1'b0);
    checkOutput("nearwrap_data", evt_data, 32'h7FFF_FFFE);
    checkHead("nearwrap");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    force dut.ts = 32'hFFFF_FFFF;
    release dut.ts;
    mts = 32'hFFFF_FFFF;
    repeat (4) decide(1'b1);
    expectEvent(1'b1);
    checkOutput("wrap_data", evt_data, 32'h8000_0002);
    checkHead("wrap");

    force dut.total_windows = 32'hFFFF_FFFF;
    release dut.total_windows;
    force dut.occ_windows = 32'hFFFF_FFFE;
    release dut.occ_windows;
    decide(1'b1);
    checkOutput("sat1_total", total_windows, 32'hFFFF_FFFF);
    checkOutput("sat1_occw", occ_windows, 32'hFFFF_FFFF);
    decide(1'b1);
    checkOutput("sat2_total", total_windows, 32'hFFFF_FFFF);
    checkOutput("sat2_occw", occ_windows, 32'hFFFF_FFFF);

    // Reset with a pending event must flush everything.
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_valid", 32'(evt_valid), 32'd0);
    checkOutput("midrst_data", evt_data, 32'd0);
    checkOutput("midrst_occupied", 32'(occupied), 32'd0);
    checkOutput("midrst_total", total_windows, 32'd0);
    checkOutput("midrst_occw", occ_windows, 32'd0);
    rst = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
